// File: rtl/fmul_arbiter_if.sv
// Request/response/multiplier bus of the two-requester FP16 multiply arbiter.
// slave: arbiter side; master: requesters, consumers and the shared multiplier.
interface fmul_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic        req0_ready;
   logic        req1_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic        rsp0_ready;
   logic        rsp1_ready;
   logic [15:0] rsp_p;
   logic [5:0]  rsp_flags;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [15:0] mul_p;
   logic [5:0]  mul_flags;

   modport slave (
      input  req0_valid, req1_valid,
      input  req0_a, req0_b, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid,
      input  rsp0_ready, rsp1_ready,
      output rsp_p, rsp_flags,
      output mul_a, mul_b,
      input  mul_p, mul_flags
   );

   modport master (
      output req0_valid, req1_valid,
      output req0_a, req0_b, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid,
      output rsp0_ready, rsp1_ready,
      input  rsp_p, rsp_flags,
      input  mul_a, mul_b,
      output mul_p, mul_flags
   );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier between two requesters.
// Ports: clk, rst (sync, active-high), bus (slave), clr_sticky, sticky_flags, busy.
module fmul_arbiter #(
   parameter int unsigned LAT     = 1,
   parameter bit          RR_INIT = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   fmul_arbiter_if.slave  bus,
   input  logic           clr_sticky,
   output logic [5:0]     sticky_flags,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] p_q, p_d;
   logic [5:0]  f_q, f_d;
   logic        own_q, own_d;
   logic        prio_q, prio_d;
   logic [5:0]  sticky_q, sticky_d;

   logic gnt0;
   logic gnt1;
   logic rsp_hs;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      p_d      = p_q;
      f_d      = f_q;
      own_d    = own_q;
      prio_d   = prio_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;

      rsp_hs = (state_q == DONE) &&
               (own_q ? bus.rsp1_ready : bus.rsp0_ready);

      unique case (state_q)
         IDLE: begin
            // req0 wins when alone or when it holds priority
            if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
               gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
               gnt1 = 1'b1;
            end
            if (gnt0 || gnt1) begin
               a_d     = gnt1 ? bus.req1_a : bus.req0_a;
               b_d     = gnt1 ? bus.req1_b : bus.req0_b;
               own_d   = gnt1;
               prio_d  = ~gnt1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               p_d     = bus.mul_p;
               f_d     = bus.mul_flags;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (rsp_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // a clear in the handshake cycle keeps only the delivered flags
      sticky_d = (clr_sticky ? 6'd0 : sticky_q) |
                 (rsp_hs ? f_q : 6'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         p_q      <= 16'd0;
         f_q      <= 6'd0;
         own_q    <= 1'b0;
         prio_q   <= RR_INIT;
         sticky_q <= 6'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         p_q      <= p_d;
         f_q      <= f_d;
         own_q    <= own_d;
         prio_q   <= prio_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.rsp0_valid = (state_q == DONE) && !own_q;
   assign bus.rsp1_valid = (state_q == DONE) && own_q;
   assign bus.rsp_p      = (state_q == DONE) ? p_q : 16'd0;
   assign bus.rsp_flags  = (state_q == DONE) ? f_q : 6'd0;
   assign bus.mul_a      = (state_q != IDLE) ? a_q : 16'd0;
   assign bus.mul_b      = (state_q != IDLE) ? b_q : 16'd0;
   assign sticky_flags   = sticky_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: LAT=1 and LAT=3 instances on shared stimulus,
// checked each cycle against a transaction-age model plus literal values.
module tb_fmul_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   always #5 clk = ~clk;

   logic        v0, v1, r0, r1;
   logic [15:0] a0, b0, a1, b1, mp;
   logic [5:0]  mf;

   fmul_arbiter_if i0 ();
   fmul_arbiter_if i1 ();

   logic [5:0] st0, st1;
   logic       bz0, bz1;

   assign i0.req0_valid = v0;
   assign i0.req1_valid = v1;
   assign i0.req0_a     = a0;
   assign i0.req0_b     = b0;
   assign i0.req1_a     = a1;
   assign i0.req1_b     = b1;
   assign i0.rsp0_ready = r0;
   assign i0.rsp1_ready = r1;
   assign i0.mul_p      = mp;
   assign i0.mul_flags  = mf;
   assign i1.req0_valid = v0;
   assign i1.req1_valid = v1;
   assign i1.req0_a     = a0;
   assign i1.req0_b     = b0;
   assign i1.req1_a     = a1;
   assign i1.req1_b     = b1;
   assign i1.rsp0_ready = r0;
   assign i1.rsp1_ready = r1;
   assign i1.mul_p      = mp;
   assign i1.mul_flags  = mf;

   fmul_arbiter #(.LAT(1), .RR_INIT(1'b0)) u0 (
      .clk          (clk),
      .rst          (rst),
      .bus          (i0.slave),
      .clr_sticky   (clr),
      .sticky_flags (st0),
      .busy         (bz0)
   );

   fmul_arbiter #(.LAT(3), .RR_INIT(1'b0)) u1 (
      .clk          (clk),
      .rst          (rst),
      .bus          (i1.slave),
      .clr_sticky   (clr),
      .sticky_flags (st1),
      .busy         (bz1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Model: a transaction is in flight for its whole life; its age counts
   // clock edges since the grant. The result is sampled when age==LAT and
   // is offered from age LAT+1 until the owner consumes it.
   bit          m_inf  [2];
   int          m_age  [2];
   bit          m_own  [2];
   bit          m_prio [2];
   logic [15:0] m_a    [2];
   logic [15:0] m_b    [2];
   logic [15:0] m_p    [2];
   logic [5:0]  m_f    [2];
   logic [5:0]  m_st   [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         automatic bit done;
         automatic bit hs;
         automatic bit g;
         done = m_inf[k] && (m_age[k] >= lat_of(k) + 1);
         hs   = done && (m_own[k] ? r1 : r0);
         g    = (v0 && v1) ? m_prio[k] : v1;
         if (rst) begin
            m_inf[k]  <= 1'b0;
            m_age[k]  <= 0;
            m_own[k]  <= 1'b0;
            m_prio[k] <= 1'b0;
            m_a[k]    <= 16'd0;
            m_b[k]    <= 16'd0;
            m_p[k]    <= 16'd0;
            m_f[k]    <= 6'd0;
            m_st[k]   <= 6'd0;
         end else begin
            m_st[k] <= (clr ? 6'd0 : m_st[k]) | (hs ? m_f[k] : 6'd0);
            if (!m_inf[k]) begin
               if (v0 || v1) begin
                  m_inf[k]  <= 1'b1;
                  m_age[k]  <= 0;
                  m_own[k]  <= g;
                  m_prio[k] <= !g;
                  m_a[k]    <= g ? a1 : a0;
                  m_b[k]    <= g ? b1 : b0;
               end
            end else if (hs) begin
               m_inf[k] <= 1'b0;
            end else if (!done) begin
               if (m_age[k] == lat_of(k)) begin
                  m_p[k] <= mp;
                  m_f[k] <= mf;
               end
               m_age[k] <= m_age[k] + 1;
            end
         end
      end
   end

   task automatic cmp(input int k, input logic q0, input logic q1,
                      input logic s0, input logic s1,
                      input logic [15:0] p, input logic [5:0] f,
                      input logic [15:0] ma, input logic [15:0] mb,
                      input logic [5:0] st, input logic bz);
      bit done;
      bit g;
      bit any;
      done = m_inf[k] && (m_age[k] >= lat_of(k) + 1);
      g    = (v0 && v1) ? m_prio[k] : v1;
      any  = !m_inf[k] && (v0 || v1);
      chk($sformatf("u%0d.req0_ready", k), 32'(q0), 32'(any && !g));
      chk($sformatf("u%0d.req1_ready", k), 32'(q1), 32'(any && g));
      chk($sformatf("u%0d.rsp0_valid", k), 32'(s0), 32'(done && !m_own[k]));
      chk($sformatf("u%0d.rsp1_valid", k), 32'(s1), 32'(done && m_own[k]));
      chk($sformatf("u%0d.rsp_p", k), 32'(p), 32'(done ? m_p[k] : 16'd0));
      chk($sformatf("u%0d.rsp_flags", k), 32'(f), 32'(done ? m_f[k] : 6'd0));
      chk($sformatf("u%0d.mul_a", k), 32'(ma), 32'(m_inf[k] ? m_a[k] : 16'd0));
      chk($sformatf("u%0d.mul_b", k), 32'(mb), 32'(m_inf[k] ? m_b[k] : 16'd0));
      chk($sformatf("u%0d.sticky", k), 32'(st), 32'(m_st[k]));
      chk($sformatf("u%0d.busy", k), 32'(bz), 32'(m_inf[k]));
   endtask

   bit chk_en = 1'b0;
   bit log_en = 1'b0;
   int gq[$];

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, i0.req0_ready, i0.req1_ready, i0.rsp0_valid, i0.rsp1_valid,
             i0.rsp_p, i0.rsp_flags, i0.mul_a, i0.mul_b, st0, bz0);
         cmp(1, i1.req0_ready, i1.req1_ready, i1.rsp0_valid, i1.rsp1_valid,
             i1.rsp_p, i1.rsp_flags, i1.mul_a, i1.mul_b, st1, bz1);
      end
      if (log_en && i0.req0_ready) gq.push_back(0);
      if (log_en && i0.req1_ready) gq.push_back(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input int k, input int bound, output int n);
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < bound) begin
         step();
         n++;
         seen = (k == 0) ? (i0.rsp0_valid || i0.rsp1_valid)
                         : (i1.rsp0_valid || i1.rsp1_valid);
      end
      chk($sformatf("u%0d.wait_rsp", k), 32'(seen), 32'd1);
   endtask

   initial begin
      int n;
      int bad;
      rst = 1'b1; clr = 1'b0;
      v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
      a0 = 16'd0; b0 = 16'd0; a1 = 16'd0; b1 = 16'd0;
      mp = 16'd0; mf = 6'd0;
      step();
      chk_en = 1'b1;
      chk("reset.busy", 32'(bz0), 32'd0);
      chk("reset.sticky", 32'(st0), 32'd0);
      chk("reset.mul_a", 32'(i0.mul_a), 32'd0);
      step();
      rst = 1'b0;

      // single LAT=1 multiply from req0
      mp = 16'h4000; mf = 6'b000001;
      a0 = 16'h3C00; b0 = 16'h4000; v0 = 1'b1;
      #1;
      chk("first.req0_ready", 32'(i0.req0_ready), 32'd1);
      step();
      v0 = 1'b0;
      chk("first.mul_a", 32'(i0.mul_a), 32'h3C00);
      wait_valid(0, 20, n);
      chk("first.latency", 32'(n), 32'd2);
      chk("first.rsp_p", 32'(i0.rsp_p), 32'h4000);
      chk("first.rsp_flags", 32'(i0.rsp_flags), 32'h01);
      repeat (6) step();
      chk("first.sticky", 32'(st0), 32'h01);
      chk("first.sticky_u1", 32'(st1), 32'h01);

      // both requesters always valid: grants alternate from req0
      rst = 1'b1;
      step();
      rst = 1'b0;
      a0 = 16'h4200; b0 = 16'h4400; a1 = 16'hC000; b1 = 16'h3800;
      mp = 16'h4A00; mf = 6'b000001;
      gq.delete();
      log_en = 1'b1;
      v0 = 1'b1; v1 = 1'b1;
      repeat (30) step();
      log_en = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      chk("rr.count", 32'(gq.size() >= 4), 32'd1);
      bad = 0;
      for (int i = 0; i < gq.size(); i++) begin
         if (gq[i] != (i % 2)) bad++;
      end
      chk("rr.alternate", 32'(bad), 32'd0);
      repeat (10) step();

      // LAT=3 result held while the consumer stalls
      r0 = 1'b0; r1 = 1'b0;
      mp = 16'h7C00; mf = 6'b001000;
      a0 = 16'h7BFF; b0 = 16'h7BFF; v0 = 1'b1;
      step();
      v0 = 1'b0;
      wait_valid(1, 20, n);
      chk("hold.latency", 32'(n), 32'd4);
      v1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold.rsp_p", 32'(i1.rsp_p), 32'h7C00);
         chk("hold.rsp_flags", 32'(i1.rsp_flags), 32'h08);
         chk("hold.req1_ready", 32'(i1.req1_ready), 32'd0);
         chk("hold.busy", 32'(bz1), 32'd1);
      end
      r0 = 1'b1; r1 = 1'b1;
      #1;
      chk("consume.no_grant", 32'(i1.req1_ready), 32'd0);
      step();
      chk("consume.grant_next", 32'(i1.req1_ready), 32'd1);
      step();
      v1 = 1'b0;
      repeat (10) step();

      // reset during WAIT drops the operation
      v0 = 1'b1;
      step();
      v0 = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstwait.busy", 32'(bz1), 32'd0);
      chk("rstwait.rsp0_valid", 32'(i1.rsp0_valid), 32'd0);
      chk("rstwait.sticky", 32'(st1), 32'd0);
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("rstwait.prio", 32'({i1.req1_ready, i1.req0_ready}), 32'b01);
      step();
      v0 = 1'b0; v1 = 1'b0;
      repeat (10) step();

      // sticky accumulation and clear-with-handshake
      clr = 1'b1;
      step();
      clr = 1'b0;
      mp = 16'h7D00; mf = 6'b100000; v0 = 1'b1;
      step();
      v0 = 1'b0;
      repeat (8) step();
      chk("sticky.first", 32'(st0), 32'h20);
      mp = 16'h0000; mf = 6'b000100; v0 = 1'b1;
      step();
      v0 = 1'b0;
      wait_valid(0, 20, n);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("sticky.clr_hs", 32'(st0), 32'h04);
      repeat (4) step();
      chk("sticky.u1", 32'(st1), 32'h04);

      // lone req1 with priority on req0
      rst = 1'b1;
      step();
      rst = 1'b0;
      v1 = 1'b1;
      #1;
      chk("lone.grant", 32'({i0.req1_ready, i0.req0_ready}), 32'b10);
      step();
      v1 = 1'b0;
      repeat (8) step();
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("lone.prio_next", 32'({i0.req1_ready, i0.req0_ready}), 32'b01);
      step();
      v0 = 1'b0; v1 = 1'b0;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning cycles from operand issue to result capture (1..15).
REQ-002 SHALL have parameter RR_INIT, default 0, meaning requester holding priority after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester has operands.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1 each  operands accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16 each  FP16 operands.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid  output  1 each  result held for requester.
REQ-009 SHALL have ports rsp0_ready/rsp1_ready  input  1 each  requester consumes result.
REQ-010 SHALL have port rsp_p  output  16  product, valid with either rsp valid.
REQ-011 SHALL have port rsp_flags  output  6  {sNaN,qNaN,inf,zero,subnormal,normal} of product.
REQ-012 SHALL have ports mul_a, mul_b  output  16 each  operands to shared multiplier.
REQ-013 SHALL have ports mul_p  input  16 and mul_flags  input  6  multiplier result and class.
REQ-014 SHALL have port sticky_flags  output  6  OR of all delivered rsp_flags since clear.
REQ-015 SHALL have port clr_sticky  input  1  clears sticky_flags.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; one operation in flight.
REQ-018 In IDLE, SHALL assert req_ready to exactly one valid requester chosen by round-robin; none if no valid.
REQ-019 Both valid in IDLE: SHALL grant the requester holding priority; priority then passes to the other.
REQ-020 Single valid requester: SHALL grant it regardless of priority; priority passes to the other requester.
REQ-021 Handshake (valid&ready) SHALL latch a, b and owner id into registers and move to ISSUE.
REQ-022 mul_a/mul_b SHALL be driven from operand registers, held constant from ISSUE through capture; 16'h0000 in IDLE.
REQ-023 ISSUE SHALL last 1 cycle, then load 4-bit counter with LAT-1 and enter WAIT.
REQ-024 WAIT SHALL decrement counter each cycle; at counter 0, SHALL capture mul_p/mul_flags into result registers and enter DONE.
REQ-025 Handshake to capture latency SHALL be LAT+1 cycles; rsp valid rises the cycle after capture.
REQ-026 In DONE, SHALL assert only owner's rsp_valid; rsp_p/rsp_flags stable until rsp_ready.
REQ-027 Owner rsp_ready in DONE SHALL return FSM to IDLE next cycle; other rsp_ready SHALL be ignored.
REQ-028 No req_ready SHALL assert outside IDLE; a new grant SHALL not occur in the rsp-consume cycle.
REQ-029 sticky_flags SHALL OR in rsp_flags on each rsp handshake; clr_sticky same cycle as handshake SHALL leave cleared-then-OR'd value (handshake flags only).
REQ-030 rsp_p/rsp_flags SHALL read 0 when no rsp valid.

Reset
REQ-031 rst SHALL force IDLE, all ready/valid low, busy 0, counter 0, operand/result registers 0, sticky_flags 0, priority RR_INIT.
REQ-032 rst mid-operation SHALL discard in-flight operation with no response delivered.
REQ-033 rst SHALL override all other inputs in the same cycle.

Verification
REQ-034 LAT=1, req0 a=16'h3C00 b=16'h4000, mul_p=16'h4000 flags=6'b000001 -> rsp0_valid 2 cycles after handshake, rsp_p 16'h4000, sticky 6'b000001.
REQ-035 Both valid every cycle, RR_INIT=0, consumers always ready -> grants alternate 0,1,0,1; no cycle with both ready.
REQ-036 LAT=3, rsp0_ready low 5 cycles in DONE -> rsp_p/rsp_flags unchanged, req ready low throughout, busy 1.
REQ-037 rst asserted during WAIT -> next cycle IDLE, busy 0, no rsp_valid, priority RR_INIT.
REQ-038 Deliver flags 6'b100000 then 6'b000100, clr_sticky with second handshake -> sticky 6'b100000 then 6'b000100.
REQ-039 Only req1 valid with priority on req0 -> req1 granted immediately, priority moves to req0.
